// File: rtl/tile_reader_pkg.sv
// Shared types and constants for the tile read path.
package tile_reader_pkg;

    localparam int ADDR_WIDTH = 18;
    localparam int DIM_W      = 10;

    typedef logic [DIM_W-1:0] dim_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/tile_reader_if.sv
// Control, BRAM read port and element stream of the tile reader, bundled as one interface.
interface tile_reader_if
    import tile_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = tile_reader_pkg::ADDR_WIDTH
);

    logic                  start;
    dim_t                  rows;
    dim_t                  cols;
    logic                  busy;
    logic                  done;
    logic                  bram_rd_en;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  start, rows, cols, bram_rd_data, out_ready,
        output busy, done, bram_rd_en, bram_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, rows, cols, bram_rd_data, out_ready,
        input  busy, done, bram_rd_en, bram_addr, out_valid, out_data, out_last
    );

endinterface

// File: rtl/tile_out_fifo.sv
// Two-entry FIFO holding {last, data} elements waiting for the consumer.
module tile_out_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         empty_o,
    output logic [1:0]   count_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tile_reader.sv
// Walks a row-major matrix in BRAM tile by tile and streams each tile, zero-padding edge tiles.
// The in-flight read slot plus a 2-entry FIFO hide the single-cycle BRAM latency.
module tile_reader
    import tile_reader_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int MAX_SIZE   = 512,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = tile_reader_pkg::ADDR_WIDTH
) (
    input logic           clk,
    input logic           rst,
    tile_reader_if.master bus
);

    localparam int TW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    localparam int CW = DIM_W + 1;
    localparam int EW = DATA_WIDTH + 1;

    state_e          state_q, state_d;
    dim_t            rows_q, rows_d, cols_q, cols_d;
    dim_t            ntr_q, ntr_d, ntc_q, ntc_d;
    dim_t            tr_q, tr_d, tc_q, tc_d;
    logic [TW-1:0]   i_q, i_d, j_q, j_d;
    logic            infl_q, infl_pad_q, infl_last_q;

    logic            legal, accept, issue, pop, room;
    logic            i_last, j_last, final_req, elem_pad, elem_last;
    logic [CW-1:0]   r_full, c_full;
    logic [ADDR_WIDTH-1:0] elem_addr;
    logic [1:0]      occ, occ_after, fifo_count;
    logic            fifo_empty, fifo_push, fifo_pop, out_valid;
    logic [EW-1:0]   fifo_head, arr_entry, out_entry;

    assign legal  = (bus.rows != '0) && (bus.rows <= dim_t'(MAX_SIZE)) &&
                    (bus.cols != '0) && (bus.cols <= dim_t'(MAX_SIZE));
    assign accept = (state_q == ST_IDLE) && bus.start && legal;

    assign r_full    = CW'(tr_q) * CW'(TILE_SIZE) + CW'(i_q);
    assign c_full    = CW'(tc_q) * CW'(TILE_SIZE) + CW'(j_q);
    assign elem_pad  = (r_full >= CW'(rows_q)) || (c_full >= CW'(cols_q));
    assign elem_addr = ADDR_WIDTH'(r_full) * ADDR_WIDTH'(cols_q) + ADDR_WIDTH'(c_full);
    assign i_last    = (i_q == TW'(TILE_SIZE - 1));
    assign j_last    = (j_q == TW'(TILE_SIZE - 1));
    assign elem_last = i_last && j_last;
    assign final_req = elem_last && (tc_q == ntc_q - dim_t'(1)) && (tr_q == ntr_q - dim_t'(1));

    // Occupancy counts buffered entries plus the read in flight; a new request
    // is allowed only if that total, after this cycle's pop, leaves a free slot.
    assign pop       = out_valid && bus.out_ready;
    assign occ       = fifo_count + {1'b0, infl_q};
    assign occ_after = occ - {1'b0, pop};
    assign room      = (occ_after <= 2'd1);
    assign issue     = (state_q == ST_FETCH) && room;

    assign bus.bram_rd_en = issue && !elem_pad;
    assign bus.bram_addr  = bus.bram_rd_en ? elem_addr : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = legal ? ST_FETCH : ST_DONE;
            ST_FETCH: if (issue && final_req) state_d = ST_DRAIN;
            ST_DRAIN: if (occ_after == 2'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            ST_FETCH, ST_DRAIN: bus.busy = 1'b1;
            ST_DONE:            bus.done = 1'b1;
            default:            ;
        endcase
    end

    always_comb begin
        rows_d = rows_q;
        cols_d = cols_q;
        ntr_d  = ntr_q;
        ntc_d  = ntc_q;
        tr_d   = tr_q;
        tc_d   = tc_q;
        i_d    = i_q;
        j_d    = j_q;
        if (accept) begin
            rows_d = bus.rows;
            cols_d = bus.cols;
            ntr_d  = dim_t'((CW'(bus.rows) + CW'(TILE_SIZE - 1)) / CW'(TILE_SIZE));
            ntc_d  = dim_t'((CW'(bus.cols) + CW'(TILE_SIZE - 1)) / CW'(TILE_SIZE));
            tr_d   = '0;
            tc_d   = '0;
            i_d    = '0;
            j_d    = '0;
        end else if (issue) begin
            if (!j_last) begin
                j_d = j_q + TW'(1);
            end else begin
                j_d = '0;
                if (!i_last) begin
                    i_d = i_q + TW'(1);
                end else begin
                    i_d = '0;
                    if (tc_q != ntc_q - dim_t'(1)) begin
                        tc_d = tc_q + dim_t'(1);
                    end else begin
                        tc_d = '0;
                        tr_d = tr_q + dim_t'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_q      <= '0;
            cols_q      <= '0;
            ntr_q       <= '0;
            ntc_q       <= '0;
            tr_q        <= '0;
            tc_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            infl_q      <= 1'b0;
            infl_pad_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            ntr_q       <= ntr_d;
            ntc_q       <= ntc_d;
            tr_q        <= tr_d;
            tc_q        <= tc_d;
            i_q         <= i_d;
            j_q         <= j_d;
            infl_q      <= issue;
            infl_pad_q  <= issue && elem_pad;
            infl_last_q <= issue && elem_last;
        end
    end

    // Returning element bypasses the FIFO when it is empty and the consumer takes it at once.
    assign arr_entry = {infl_last_q, infl_pad_q ? {DATA_WIDTH{1'b0}} : bus.bram_rd_data};
    assign fifo_push = infl_q && !(fifo_empty && pop);
    assign fifo_pop  = pop && !fifo_empty;

    tile_out_fifo #(
        .W(EW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (fifo_push),
        .data_i (arr_entry),
        .pop_i  (fifo_pop),
        .empty_o(fifo_empty),
        .count_o(fifo_count),
        .data_o (fifo_head)
    );

    always_comb begin
        out_valid = !fifo_empty || infl_q;
        out_entry = '0;
        if (!fifo_empty)  out_entry = fifo_head;
        else if (infl_q)  out_entry = arr_entry;
    end

    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_entry[EW-1];
    assign bus.out_data  = out_entry[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_tile_reader.sv
// Randomised bench for tile_reader: BRAM model, tile-order reference queue and per-beat checks.
module tb_tile_reader;

    localparam int T  = 4;
    localparam int DW = 32;
    localparam int AW = 18;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    tile_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    tile_reader #(
        .TILE_SIZE (T),
        .MAX_SIZE  (512),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Unread cycles return garbage so that unzeroed pads show up.
    always @(posedge clk) begin
        bus.bram_rd_data <= bus.bram_rd_en ? mem[bus.bram_addr] : DW'($urandom);
    end

    int            n_vec = 0;
    int            n_err = 0;
    beat_t         exp_q[$];
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] ref_rx[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void build_ref(input int r, input int c);
        int ntr;
        int ntc;
        ntr = (r + T - 1) / T;
        ntc = (c + T - 1) / T;
        exp_q.delete();
        for (int a = 0; a < ntr; a++)
            for (int b = 0; b < ntc; b++)
                for (int i = 0; i < T; i++)
                    for (int j = 0; j < T; j++) begin
                        int    rr;
                        int    cc;
                        beat_t e;
                        rr     = a * T + i;
                        cc     = b * T + j;
                        e.last = (i == T - 1) && (j == T - 1);
                        e.data = (rr < r && cc < c) ? mem[rr * c + cc] : '0;
                        exp_q.push_back(e);
                    end
    endfunction

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_busy"}, 64'(bus.busy), 64'(0));
        chk({pfx, "_done"}, 64'(bus.done), 64'(0));
        chk({pfx, "_rd_en"}, 64'(bus.bram_rd_en), 64'(0));
        chk({pfx, "_addr"}, 64'(bus.bram_addr), 64'(0));
        chk({pfx, "_valid"}, 64'(bus.out_valid), 64'(0));
        chk({pfx, "_data"}, 64'(bus.out_data), 64'(0));
        chk({pfx, "_last"}, 64'(bus.out_last), 64'(0));
    endtask

    // fill: 0 = value equals address, 1 = random, 2 = keep memory as is.
    task automatic run_job(input int r, input int c, input int fill, input int rdy_pct,
                           input int kick_at, input int rst_at);
        int    beats, reads, cyc, last_hs, budget, maxocc, total;
        bit    done_seen, stall_prev, legal, kicked;
        beat_t e, held;
        legal = (r >= 1 && r <= 512 && c >= 1 && c <= 512);
        if (legal && fill != 2)
            for (int a = 0; a < r * c; a++) mem[a] = (fill == 1) ? DW'($urandom) : DW'(a);
        if (legal) build_ref(r, c);
        else       exp_q.delete();
        total = exp_q.size();
        rx_q.delete();

        @(negedge clk);
        bus.start     = 1'b1;
        bus.rows      = 10'(r);
        bus.cols      = 10'(c);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;

        if (!legal) begin
            chk("ill_done", 64'(bus.done), 64'(1));
            for (int k = 0; k < 4; k++) begin
                chk("ill_busy", 64'(bus.busy), 64'(0));
                chk("ill_rd_en", 64'(bus.bram_rd_en), 64'(0));
                chk("ill_valid", 64'(bus.out_valid), 64'(0));
                if (k > 0) chk("ill_done_pulse", 64'(bus.done), 64'(0));
                @(negedge clk);
                #1;
            end
            return;
        end

        chk("busy_n1", 64'(bus.busy), 64'(1));
        chk("rd_en_n1", 64'(bus.bram_rd_en), 64'(1));
        chk("addr_n1", 64'(bus.bram_addr), 64'(0));
        chk("valid_n1", 64'(bus.out_valid), 64'(0));
        reads      = bus.bram_rd_en ? 1 : 0;
        beats      = 0;
        cyc        = 0;
        last_hs    = -1;
        done_seen  = 1'b0;
        stall_prev = 1'b0;
        kicked     = 1'b0;
        maxocc     = 0;
        held       = '0;
        budget     = total * 20 + 50;

        while (!done_seen && cyc < budget) begin
            @(negedge clk);
            bus.out_ready = (int'($urandom_range(99)) < rdy_pct);
            if (!kicked && kick_at >= 0 && beats >= kick_at) begin
                bus.start = 1'b1;
                bus.rows  = 10'd2;
                bus.cols  = 10'd2;
                kicked    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            cyc++;
            if (int'(dut.u_fifo.count_o) > maxocc) maxocc = int'(dut.u_fifo.count_o);
            if (cyc == 1) chk("valid_n2", 64'(bus.out_valid), 64'(1));
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.out_valid), 64'(1));
                chk("stall_hold", 64'({bus.out_last, bus.out_data}), 64'(held));
            end
            if (bus.bram_rd_en) reads++;
            if (bus.done) begin
                done_seen = 1'b1;
                chk("done_latency", 64'(cyc), 64'(last_hs + 1));
                chk("busy_at_done", 64'(bus.busy), 64'(0));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(beats + 1), 64'(total));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(bus.out_data), 64'(e.data));
                    chk("beat_last", 64'(bus.out_last), 64'(e.last));
                end
                rx_q.push_back(bus.out_data);
                beats++;
                last_hs = cyc;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held       = {bus.out_last, bus.out_data};
            if (rst_at >= 0 && beats == rst_at) begin
                @(negedge clk);
                rst = 1'b0;
                #1;
                check_all_zero("rst_mid");
                repeat (2) @(negedge clk);
                rst = 1'b1;
                return;
            end
        end

        chk("done_seen", 64'(done_seen), 64'(1));
        chk("beat_count", 64'(beats), 64'(total));
        chk("read_count", 64'(reads), 64'(r * c));
        chk("occ_le_2", 64'(maxocc <= 2), 64'(1));
        @(negedge clk);
        #1;
        chk("done_pulse", 64'(bus.done), 64'(0));
        chk("busy_idle", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.rows      = '0;
        bus.cols      = '0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_job(4, 4, 0, 100, -1, -1);

        run_job(5, 6, 0, 100, -1, -1);
        chk("t56_size", 64'(rx_q.size()), 64'(64));
        if (rx_q.size() == 64) begin
            chk("t01_r0_c0", 64'(rx_q[16]), 64'(4));
            chk("t01_r0_c1", 64'(rx_q[17]), 64'(5));
            chk("t01_r0_c2", 64'(rx_q[18]), 64'(0));
            chk("t01_r0_c3", 64'(rx_q[19]), 64'(0));
            chk("t11_e0", 64'(rx_q[48]), 64'(28));
            chk("t11_e1", 64'(rx_q[49]), 64'(29));
            for (int k = 50; k < 64; k++) chk("t11_pad", 64'(rx_q[k]), 64'(0));
        end

        run_job(8, 8, 1, 100, -1, -1);
        ref_rx = rx_q;
        run_job(8, 8, 2, 30, -1, -1);
        chk("replay_size", 64'(rx_q.size()), 64'(ref_rx.size()));
        for (int k = 0; k < rx_q.size() && k < ref_rx.size(); k++)
            chk("replay_beat", 64'(rx_q[k]), 64'(ref_rx[k]));

        run_job(0, 4, 0, 100, -1, -1);
        run_job(4, 513, 0, 100, -1, -1);

        run_job(8, 8, 0, 100, 20, -1);
        run_job(7, 3, 1, 60, 5, -1);

        run_job(4, 8, 0, 100, -1, 8);
        run_job(4, 8, 0, 100, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tile_reader.md
# tile_reader

Read-side counterpart to the tiling write path. Once a row-major matrix sits in the global BRAM, `tile_reader` walks it in TILE_SIZE×TILE_SIZE tiles and streams each tile element by element over a valid/ready interface to the compute array. Edge tiles are zero-padded. A 2-entry output buffer absorbs the 1-cycle BRAM read latency, so the stream runs at one element per cycle under no backpressure.

## Interface
- TILE_SIZE, 4: tile edge, in elements.
- MAX_SIZE, 512: maximum matrix rows and maximum matrix cols.
- DATA_WIDTH, 32: element width.
- ADDR_WIDTH, 18: BRAM address width, equal to $clog2(MAX_SIZE*MAX_SIZE).
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- rows  in  10  matrix rows; captured when start is accepted.
- cols  in  10  matrix cols; captured when start is accepted.
- busy  out  1  high from start acceptance until the done pulse.
- done  out  1  one-cycle pulse at job end.
- bram_rd_en  out  1  read strobe.
- bram_addr  out  ADDR_WIDTH  read address.
- bram_rd_data  in  DATA_WIDTH  read data; valid exactly 1 cycle after bram_rd_en.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_WIDTH  element data.
- out_last  out  1  marks the last element of each tile.

## Operation
- FSM states are IDLE, FETCH, DRAIN, DONE.
- IDLE → FETCH on start, when rows and cols are both in 1..MAX_SIZE.
- IDLE → DONE on start with an illegal dimension (0 or >MAX_SIZE). No BRAM reads and no beats occur.
- FETCH → DRAIN after the final element request is issued.
- DRAIN → DONE when the buffer is empty, nothing is in flight, and the last beat has handshaken.
- DONE → IDLE unconditionally after 1 cycle. done=1 only in DONE.
- Traversal uses four counters:
  - tile-row index tr, range 0..ceil(rows/T)-1 (outermost);
  - tile-col index tc, range 0..ceil(cols/T)-1;
  - in-tile row i, range 0..T-1;
  - in-tile col j, range 0..T-1 (innermost).
- Element coordinates are r = tr*T+i and c = tc*T+j. The address is r*cols+c, computed at full ADDR_WIDTH with no truncation.
- If r≥rows or c≥cols, the element is a pad:
  - no BRAM read is issued;
  - the slot still occupies one pipeline cycle;
  - it is emitted with out_data=0.
- out_last=1 when i=T-1 and j=T-1.
- Each element request (read or pad) carries a pad bit and a last bit through the 1-cycle stage into the buffer.
- Issue rule: a request is issued only if entries + in_flight − pop ≤ 1, where pop = out_valid & out_ready in that cycle. The buffer never overflows and no data is lost.
- out_valid = (buffer non-empty). Buffer order is FIFO. out_data and out_last are stable while out_valid=1 and out_ready=0.
- start while busy is ignored, with no effect on the running job.
- Reset mid-job returns to IDLE and clears the buffer. Any BRAM data returning after reset is dropped.

## Timing
- Reset values: busy, done, bram_rd_en, out_valid, out_last = 0; bram_addr, out_data = 0.
- start in cycle N produces:
  - busy=1 from N+1;
  - first request in N+1;
  - first out_valid in N+2.
- With out_ready held high, the stream is one beat per cycle with no bubbles, including across tile boundaries and pad elements.
- Total beats = ceil(rows/T)·ceil(cols/T)·T².
- done is asserted the cycle after the final beat handshake. busy drops in that same cycle.
- For an illegal dimension: done at N+1, busy never asserted.

## Structure
- A shared package holds:
  - the FSM state enum;
  - ADDR_WIDTH;
  - the dimension width (10).
- One sub-module, `tile_out_fifo`, is natural: a 2-entry FIFO of {last, data} with push, pop, empty, count.
- Address generation and the FSM stay in `tile_reader`.

## Test plan
- 4×4 matrix holding values 0..15, out_ready=1:
  - 16 beats in order 0..15;
  - out_last on beat 15 only;
  - done 1 cycle after beat 15.
- 5×6 matrix with value = addr:
  - 4 tiles, 64 beats;
  - tile(0,1) row 0 is 4,5,0,0;
  - tile(1,1) holds 28,29 then 14 zeros;
  - no BRAM read for any pad.
- 8×8 with random out_ready at 30% duty:
  - beat sequence identical to the out_ready=1 run;
  - out_data stable while stalled;
  - never more than 2 entries buffered.
- Illegal dimensions (rows=0, and cols=513):
  - done pulses the cycle after start;
  - no bram_rd_en and no out_valid.
- start pulsed mid-job:
  - ignored; the beat count is unchanged.
- rst asserted after beat 7 of a 4×8 job:
  - all outputs 0 immediately;
  - a new start produces a clean job from element 0.
